// File: rtl/game_state_if.sv
// rtl/game_state_if.sv - game scorer interface with controller and scorer views
//
// Purpose : bundles the game controls and results between the controller and
//           the game_state scorer. Clock and reset stay plain module ports.
// Signals : control[1:0]  counter mode (00 +1, 01 +2, 10 -1, 11 -2)
//           INIT          load i_value into the counter, clear the score
//           i_value       counter load value, COUNTER_SIZE bits
//           who[1:0]      00 none, 01 loser reached 15, 10 winner reached 15
//           los / win     registered loss / win flags
//           gameover      one-cycle end-of-game pulse
//           wins_o/losses_o  tally mirrors, only with GAME_STATE_SCORE_PORTS_EN
// Modports: master (controller side), dut / slave (scorer side).
interface game_state_if #(
   parameter int COUNTER_SIZE = 4
);
   logic [1:0]              control;
   logic                    INIT;
   logic [COUNTER_SIZE-1:0] i_value;
   logic [1:0]              who;
   logic                    los;
   logic                    win;
   logic                    gameover;
`ifdef GAME_STATE_SCORE_PORTS_EN
   logic [3:0]              wins_o;
   logic [3:0]              losses_o;
`endif

   modport master (
      output control, INIT, i_value,
`ifdef GAME_STATE_SCORE_PORTS_EN
      input  wins_o, losses_o,
`endif
      input  who, los, win, gameover
   );

   modport dut (
      input  control, INIT, i_value,
`ifdef GAME_STATE_SCORE_PORTS_EN
      output wins_o, losses_o,
`endif
      output who, los, win, gameover
   );

   modport slave (
      input  control, INIT, i_value,
`ifdef GAME_STATE_SCORE_PORTS_EN
      output wins_o, losses_o,
`endif
      output who, los, win, gameover
   );
endinterface

// File: rtl/game_state.sv
// rtl/game_state.sv - two-outcome game scorer around a multi-mode up/down counter
//
// Purpose : classifies the counter every cycle as win (all-ones), loss (zero)
//           or neutral, tallies wins and losses, and reports the winner with
//           a one-cycle gameover pulse when a tally reaches 15, then restarts.
// Ports   : clk   rising-edge clock
//           reset synchronous, active-low
//           g     game_state_if.dut (control, INIT, i_value in;
//                 who, los, win, gameover out)
// Option  : GAME_STATE_SCORE_PORTS_EN adds wins_o/losses_o tally mirrors.
module game_state #(
   parameter int COUNTER_SIZE = 4
) (
   input  logic        clk,
   input  logic        reset,
   game_state_if.dut   g
);
   localparam logic [COUNTER_SIZE-1:0] C_ALL_ONES = '1;
   localparam logic [COUNTER_SIZE-1:0] C_ONE      = COUNTER_SIZE'(1);
   localparam logic [COUNTER_SIZE-1:0] C_TWO      = COUNTER_SIZE'(2);

   logic [COUNTER_SIZE-1:0] r_count;
   logic [COUNTER_SIZE-1:0] w_step;
   logic [3:0]              r_wins;
   logic [3:0]              r_losses;
   logic [3:0]              w_wins_nxt;
   logic [3:0]              w_losses_nxt;
   logic [1:0]              r_who;
   logic                    r_win;
   logic                    r_los;
   logic                    r_gameover;
   logic                    w_start_over;
   logic                    w_is_win;
   logic                    w_is_loss;

   // gameover feeds back into the restart, so it and who last one cycle.
   assign w_start_over = !reset || r_gameover;

   // Down-steps are added as two's-complement so wrap-around is natural.
   always_comb begin
      w_step = C_ONE;
      case (g.control)
         2'b00:   w_step = C_ONE;
         2'b01:   w_step = C_TWO;
         2'b10:   w_step = C_ALL_ONES;
         default: w_step = ~C_ONE;
      endcase
   end

   // Classification uses the pre-step count sampled at this edge.
   assign w_is_win     = (r_count == C_ALL_ONES);
   assign w_is_loss    = (r_count == '0);
   assign w_wins_nxt   = r_wins + {3'b000, w_is_win};
   assign w_losses_nxt = r_losses + {3'b000, w_is_loss};

   always_ff @(posedge clk) begin
      if (w_start_over) begin
         r_count <= '0;
      end else if (g.INIT) begin
         r_count <= g.i_value;
      end else begin
         r_count <= r_count + w_step;
      end
   end

   always_ff @(posedge clk) begin
      if (w_start_over || g.INIT) begin
         r_who      <= 2'b00;
         r_win      <= 1'b0;
         r_los      <= 1'b0;
         r_gameover <= 1'b0;
         r_wins     <= 4'd0;
         r_losses   <= 4'd0;
      end else begin
         r_win      <= w_is_win;
         r_los      <= w_is_loss;
         r_wins     <= w_wins_nxt;
         r_losses   <= w_losses_nxt;
         r_gameover <= (w_wins_nxt == 4'd15) || (w_losses_nxt == 4'd15);
         // A winner outranks a simultaneous loser; otherwise who holds.
         if (w_wins_nxt == 4'd15) begin
            r_who <= 2'b10;
         end else if (w_losses_nxt == 4'd15) begin
            r_who <= 2'b01;
         end
      end
   end

   assign g.who      = r_who;
   assign g.win      = r_win;
   assign g.los      = r_los;
   assign g.gameover = r_gameover;
`ifdef GAME_STATE_SCORE_PORTS_EN
   assign g.wins_o   = r_wins;
   assign g.losses_o = r_losses;
`endif
endmodule

// File: tb/tb_game_state.sv
// tb/tb_game_state.sv - self-checking bench for game_state
module tb_game_state;
   logic clk;
   logic reset;

   game_state_if #(.COUNTER_SIZE(4)) gif();

   game_state #(.COUNTER_SIZE(4)) dut (
      .clk   (clk),
      .reset (reset),
      .g     (gif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;

   // Game model: plain integers, score rules applied directly.
   int m_count  = 0;
   int m_wins   = 0;
   int m_losses = 0;
   int m_who    = 0;
   int m_win    = 0;
   int m_los    = 0;
   int m_go     = 0;

   function automatic void chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endfunction

   function automatic void model_step(input bit rst, input bit init, input int ctl, input int val);
      int pre;
      int delta;
      bit restart;
      restart = !rst || (m_go != 0);
      pre = m_count;
      case (ctl)
         0:       delta = 1;
         1:       delta = 2;
         2:       delta = -1;
         default: delta = -2;
      endcase
      if (restart)   m_count = 0;
      else if (init) m_count = val % 16;
      else           m_count = (m_count + delta + 16) % 16;
      if (restart || init) begin
         m_who = 0; m_win = 0; m_los = 0; m_go = 0; m_wins = 0; m_losses = 0;
      end else begin
         m_win = (pre == 15) ? 1 : 0;
         m_los = (pre == 0) ? 1 : 0;
         m_wins   += m_win;
         m_losses += m_los;
         m_go = 0;
         if (m_losses == 15) begin m_who = 1; m_go = 1; end
         if (m_wins == 15)   begin m_who = 2; m_go = 1; end
      end
   endfunction

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("who",      int'(gif.who),      m_who);
         chk("win",      int'(gif.win),      m_win);
         chk("los",      int'(gif.los),      m_los);
         chk("gameover", int'(gif.gameover), m_go);
`ifdef GAME_STATE_SCORE_PORTS_EN
         chk("wins_o",   int'(gif.wins_o),   m_wins);
         chk("losses_o", int'(gif.losses_o), m_losses);
`endif
      end
   end

   task automatic tick(input bit rst, input bit init, input int ctl, input int val);
      reset       = rst;
      gif.INIT    = init;
      gif.control = ctl[1:0];
      gif.i_value = val[3:0];
      @(posedge clk);
      model_step(rst, init, ctl, val);
      @(negedge clk);
      #1;
   endtask

   task automatic run_go(input int ctl, input int maxc, output int n);
      n = 0;
      while (1) begin
         tick(1'b1, 1'b0, ctl, 0);
         n++;
         if (gif.gameover === 1'b1) break;
         if (n >= maxc) begin
            n_tests++;
            n_fail++;
            $display("FAIL gameover_timeout after %0d cycles, required a gameover", n);
            break;
         end
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_who"}, int'(gif.who), 0);
      chk({tag, "_win"}, int'(gif.win), 0);
      chk({tag, "_los"}, int'(gif.los), 0);
      chk({tag, "_go"},  int'(gif.gameover), 0);
   endtask

   int n;

   initial begin
      reset       = 1'b0;
      gif.INIT    = 1'b0;
      gif.control = 2'b00;
      gif.i_value = 4'd0;

      // Reset held for two cycles
      tick(1'b0, 1'b0, 0, 0);
      cmp_en = 1'b1;
      tick(1'b0, 1'b0, 0, 0);
      chk_all_zero("reset");

      // Release: counter starts at zero so the first edge is a loss
      tick(1'b1, 1'b0, 0, 0);
      chk("start_los1", int'(gif.los), 1);
      tick(1'b1, 1'b0, 0, 0);
      chk("start_los0", int'(gif.los), 0);

      // INIT to 14, count up: win two edges later, then wrap to zero
      tick(1'b1, 1'b1, 0, 14);
      tick(1'b1, 1'b0, 0, 0);
      tick(1'b1, 1'b0, 0, 0);
      chk("init_win", int'(gif.win), 1);
      tick(1'b1, 1'b0, 0, 0);
      chk("wrap_win0", int'(gif.win), 0);
      chk("wrap_los1", int'(gif.los), 1);

      // Loser game: +2 from reset hits zero every 8 edges
      tick(1'b0, 1'b0, 1, 0);
      run_go(1, 200, n);
      chk("lose_cycles", n, 113);
      chk("lose_who", int'(gif.who), 1);
      tick(1'b1, 1'b0, 1, 0);
      chk_all_zero("lose_after");

      // Winner game: INIT 15 then -2 hits all-ones every 8 edges
      tick(1'b1, 1'b1, 0, 15);
      run_go(3, 200, n);
      chk("win_cycles", n, 113);
      chk("win_who", int'(gif.who), 2);
      tick(1'b1, 1'b0, 3, 0);
      chk_all_zero("win_after");
      tick(1'b1, 1'b0, 3, 0);
      chk("restart_los", int'(gif.los), 1);

      // Reset mid-game after five losses
      tick(1'b0, 1'b0, 1, 0);
      for (int i = 0; i < 33; i++) tick(1'b1, 1'b0, 1, 0);
      chk("mid_los5", int'(gif.los), 1);
      tick(1'b0, 1'b0, 1, 0);
      chk_all_zero("midrst");
      run_go(1, 200, n);
      chk("midrst_cycles", n, 113);
      chk("midrst_who", int'(gif.who), 1);
      tick(1'b1, 1'b0, 1, 0);

      // INIT mid-game after ten losses, then count down from 7
      for (int i = 0; i < 73; i++) tick(1'b1, 1'b0, 1, 0);
      chk("mid_los10", int'(gif.los), 1);
      tick(1'b1, 1'b1, 0, 7);
      chk_all_zero("midinit");
      run_go(2, 400, n);
      chk("midinit_cycles", n, 232);
      chk("midinit_who", int'(gif.who), 1);
      tick(1'b1, 1'b0, 2, 0);
      chk_all_zero("midinit_after");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
